route_cmd_cntrl: RTL
====================

# route_cmd_cntrl

Parametrised vehicle command controller for the line-follower: accepts GO/STOP/ADD commands from the command UART path, holds a queue of destination barcode IDs, and drives `in_transit`/`go` toward the motion controller. Successive stops are visited in order with a fixed dwell at each intermediate stop. It also drives the differential obstacle buzzer.

## Interface
Parameters:
- `ID_W`, 6: destination ID width taken from `cmd[ID_W-1:0]`; legal range 1..6.
- `DEPTH`, 4: destination queue depth; power of 2, at least 2.
- `BUZZ_PERIOD`, 12500: buzzer period in clk cycles; even, at least 2.
- `DWELL_CYC`, 1000: cycles stopped at an intermediate destination; at least 1.
- `OBST_TIMEOUT`, 500000: blocked-cycle limit, used only with `OBST_TIMEOUT_EN`.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `cmd`, in, 8: `[7:6]` opcode, `[ID_W-1:0]` destination.
- `cmd_rdy`, in, 1: command valid.
- `clr_cmd_rdy`, out, 1: command consumed.
- `ID`, in, 8: barcode ID.
- `ID_vld`, in, 1: ID valid.
- `clr_ID_vld`, out, 1: ID consumed.
- `OK2Move`, in, 1: 0 means an obstacle is present.
- `in_transit`, out, 1: vehicle should be travelling.
- `go`, out, 1: `in_transit & OK2Move`.
- `buzz`, out, 1: buzzer positive drive.
- `buzz_n`, out, 1: buzzer negative drive.
- `arrived`, out, 1: 1-cycle pulse when the final queued destination is reached.
- `cmd_drop`, out, 1: 1-cycle pulse when an ADD is rejected because the queue is full.
- `q_count`, out, `$clog2(DEPTH+1)`: queue occupancy.
- `timeout`, out, 1: 1-cycle abort pulse; constant 0 without the macro.

## Operation
- **Opcodes:**
  - 00 STOP: flush the queue, go to IDLE.
  - 01 GO: flush the queue, enqueue `dest`, go to MOVING.
  - 10 ADD: enqueue `dest`. If the queue is full, discard `dest` and pulse `cmd_drop`.
  - 11: consumed, no effect.
- **States:**
  - IDLE: `in_transit`=0.
  - MOVING: `in_transit`=1.
  - DWELL: `in_transit`=0; a dwell counter runs.
- **Transitions:**
  - IDLE to MOVING on GO, or on an accepted ADD.
  - In MOVING, on `ID_vld`, compare `ID` against `{0, head}`:
    - mismatch: stay in MOVING.
    - match with other entries remaining: pop the head, go to DWELL.
    - match with this the last entry: pop, go to IDLE, pulse `arrived`.
  - DWELL to MOVING after `DWELL_CYC` cycles.
  - STOP from any state goes to IDLE.
  - GO from any state goes to MOVING.
- **ID consumption:** `clr_ID_vld` is asserted for every `ID_vld` cycle, in every state. In IDLE and DWELL the ID is discarded.
- **Buzzer enable:** enabled when `in_transit & ~OK2Move`.
- **Buzzer waveform while enabled:**
  - The counter runs 0..`BUZZ_PERIOD-1` and wraps.
  - `buzz` = 1 when the counter is at or above `BUZZ_PERIOD/2`; `buzz_n` = `~buzz`.
- **Buzzer disabled:** counter held at 0, `buzz` = `buzz_n` = 0.

## Timing
- **Reset values:**
  - state IDLE, queue empty, all counters 0.
  - every output 0, including `q_count`.
- **Command handshake:**
  - `clr_cmd_rdy` is combinational and equals `cmd_rdy`; the command is acted on at that clock edge.
  - The sender deasserts `cmd_rdy` the next cycle.
- **ID handshake:** `clr_ID_vld` is combinational, the same cycle as `ID_vld`, except in the collision case below.
- **Latency:**
  - state, queue and `q_count` update at the accepting edge.
  - `in_transit` changes the cycle after acceptance.
  - `arrived`, `cmd_drop` and `timeout` are registered and pulse the cycle after the causing edge.
- **Collision:** `cmd_rdy` and `ID_vld` in the same MOVING cycle.
  - The command wins; `clr_ID_vld`=0 and the ID is evaluated in a later cycle.
  - After GO, the retained ID is compared against the new head.
- **ADD in DWELL or MOVING:** appended at the tail; no state change.
- **ADD while full in IDLE:** impossible, since IDLE implies the queue is empty.
- **Queue pointers:** wrap modulo `DEPTH`; full when `q_count == DEPTH`.
- **Dwell counter:** cleared on entry to DWELL; the exit edge is the `DWELL_CYC`-th cycle in DWELL.
- **Reset mid-operation:** asynchronous clear to the reset values; any in-flight command is lost.

## Configuration
- `OBST_TIMEOUT_EN` defined:
  - A blocked counter increments each cycle that `in_transit & ~OK2Move` holds; it clears otherwise.
  - On reaching `OBST_TIMEOUT`: flush the queue, go to IDLE, pulse `timeout`.
  - A command in the same cycle takes priority over the timeout.
- `OBST_TIMEOUT_EN` undefined: no counter is built; `timeout` is tied to 0.

## Structure
- **Package `route_pkg`:**
  - `state_t` enum: IDLE, MOVING, DWELL.
  - opcode localparams: `OP_STOP`=2'b00, `OP_GO`=2'b01, `OP_ADD`=2'b10.
- **Sub-module `route_fifo`:**
  - parametrised by `W`, `DEPTH`.
  - ports: `push`, `pop`, `flush`, `din`, `head`, `count`, `full`, `empty`.
  - `flush` has priority over `push`/`pop`; simultaneous `push`/`pop` keeps the count.
- **Top level:** FSM, dwell counter, buzzer counter and the optional timeout counter.

## Test plan
- GO 0x45, then `ID`=0x03 then 0x05 → first ID consumed while still MOVING; on the second, IDLE, `arrived` pulse, `in_transit`=0.
- GO 0x41, ADD 0x82, ADD 0x83, `ID`=0x01 → DWELL for exactly `DWELL_CYC` cycles, then MOVING; `q_count` goes 3, then 2.
- `DEPTH`=4: GO, then 4× ADD → fourth ADD gives a `cmd_drop` pulse; `q_count` stays 4.
- MOVING, `OK2Move`=0 → `buzz` toggles with period `BUZZ_PERIOD` and `buzz_n`=`~buzz`; when `OK2Move`=1, both are 0 next cycle and `go`=1.
- `cmd_rdy` (STOP) and `ID_vld` matching the head in the same cycle → `clr_ID_vld`=0, state IDLE, no `arrived` pulse.
- With `OBST_TIMEOUT_EN` and `OBST_TIMEOUT`=16: blocked for 16 cycles → `timeout` pulse, IDLE, `q_count`=0; an unblock at cycle 15 gives no timeout.

Source files
------------

// File: rtl/route_pkg.sv
// Shared types and opcodes for the route command controller.
package route_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MOVING,
        DWELL
    } state_t;

    localparam logic [1:0] OP_STOP = 2'b00;
    localparam logic [1:0] OP_GO   = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;

endpackage

// File: rtl/route_fifo.sv
// Destination queue for the route command controller: power-of-two circular buffer
// with a flush that empties the queue and can take a push in the same cycle.
module route_fifo #(
    parameter int unsigned W     = 6,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [W-1:0]                 din,
    output logic [W-1:0]                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            // Old contents are discarded; a push in the same cycle becomes the sole entry.
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            if (push) begin
                mem_d[0] = din;
                wr_ptr_d = PTR_W'(1);
                count_d  = CNT_W'(1);
            end
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop_ok && !push_ok) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/route_cmd_cntrl.sv
// Line-follower command controller: destination queue, travel/dwell FSM and obstacle buzzer.
// Define OBST_TIMEOUT_EN to build the blocked-obstacle abort counter.
module route_cmd_cntrl #(
    parameter int unsigned ID_W         = 6,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned BUZZ_PERIOD  = 12500,
    parameter int unsigned DWELL_CYC    = 1000,
    parameter int unsigned OBST_TIMEOUT = 500000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  cmd,
    input  logic                        cmd_rdy,
    output logic                        clr_cmd_rdy,
    input  logic [7:0]                  ID,
    input  logic                        ID_vld,
    output logic                        clr_ID_vld,
    input  logic                        OK2Move,
    output logic                        in_transit,
    output logic                        go,
    output logic                        buzz,
    output logic                        buzz_n,
    output logic                        arrived,
    output logic                        cmd_drop,
    output logic [$clog2(DEPTH+1)-1:0]  q_count,
    output logic                        timeout
);

    import route_pkg::*;

    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned BUZZ_W  = $clog2(BUZZ_PERIOD);
    localparam int unsigned DWELL_W = $clog2(DWELL_CYC + 1);

    state_t             state_q, state_d;
    logic [1:0]         cmd_op;
    logic [ID_W-1:0]    dest;
    logic               fifo_push, fifo_pop, fifo_flush;
    logic [ID_W-1:0]    fifo_head;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full, fifo_empty;
    logic [7:0]         head_ext;
    logic               id_match, is_last, dwell_done, timeout_hit, buzz_en;
    logic               arrived_q, arrived_d;
    logic               cmd_drop_q, cmd_drop_d;
    logic               timeout_q, timeout_d;
    logic [BUZZ_W-1:0]  buzz_cnt_q, buzz_cnt_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic               unused_bits;

    assign cmd_op      = cmd[7:6];
    assign dest        = cmd[ID_W-1:0];
    assign head_ext    = 8'(fifo_head);
    assign unused_bits = ^{cmd, fifo_empty};

    // A pending command owns the cycle, so the ID is only judged when no command is present.
    assign id_match   = ID_vld & ~cmd_rdy & (state_q == MOVING) & (ID == head_ext);
    assign is_last    = (fifo_count == CNT_W'(1));
    assign dwell_done = (state_q == DWELL) && (dwell_cnt_q == DWELL_W'(DWELL_CYC - 1));

    route_fifo #(
        .W     (ID_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .din   (dest),
        .head  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef OBST_TIMEOUT_EN
    localparam int unsigned BLK_W = $clog2(OBST_TIMEOUT + 1);
    logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
    logic             blk_limit;

    assign blk_limit   = (blk_cnt_q >= BLK_W'(OBST_TIMEOUT - 1));
    assign timeout_hit = buzz_en & ~cmd_rdy & blk_limit;

    // Saturates so a command that pre-empts the abort only defers it.
    always_comb begin
        blk_cnt_d = '0;
        if (buzz_en) begin
            blk_cnt_d = blk_limit ? blk_cnt_q : blk_cnt_q + BLK_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt_q <= '0;
        end else begin
            blk_cnt_q <= blk_cnt_d;
        end
    end
`else
    logic unused_timeout;
    assign timeout_hit    = 1'b0;
    assign unused_timeout = |OBST_TIMEOUT;
`endif

    always_comb begin
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
        arrived_d  = 1'b0;
        cmd_drop_d = 1'b0;
        timeout_d  = 1'b0;
        if (cmd_rdy) begin
            case (cmd_op)
                OP_STOP: fifo_flush = 1'b1;
                OP_GO: begin
                    fifo_flush = 1'b1;
                    fifo_push  = 1'b1;
                end
                OP_ADD: begin
                    cmd_drop_d = fifo_full;
                    fifo_push  = ~fifo_full;
                end
                default: ;
            endcase
        end else if (timeout_hit) begin
            fifo_flush = 1'b1;
            timeout_d  = 1'b1;
        end else if (id_match) begin
            fifo_pop  = 1'b1;
            arrived_d = is_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MOVING: if (id_match) state_d = is_last ? IDLE : DWELL;
            DWELL:  if (dwell_done) state_d = MOVING;
            default: ;
        endcase
        if (cmd_rdy) begin
            case (cmd_op)
                OP_STOP: state_d = IDLE;
                OP_GO:   state_d = MOVING;
                OP_ADD:  if (state_q == IDLE) state_d = MOVING;
                default: ;
            endcase
        end else if (timeout_hit) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        in_transit  = (state_q == MOVING);
        go          = in_transit & OK2Move;
        buzz_en     = in_transit & ~OK2Move;
        buzz        = buzz_en & (buzz_cnt_q >= BUZZ_W'(BUZZ_PERIOD / 2));
        buzz_n      = buzz_en & ~buzz;
        clr_cmd_rdy = cmd_rdy;
        clr_ID_vld  = ID_vld & ~(cmd_rdy & in_transit);
    end

    always_comb begin
        buzz_cnt_d = '0;
        if (buzz_en && buzz_cnt_q != BUZZ_W'(BUZZ_PERIOD - 1)) begin
            buzz_cnt_d = buzz_cnt_q + BUZZ_W'(1);
        end
        dwell_cnt_d = '0;
        if (state_q == DWELL && state_d == DWELL) begin
            dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buzz_cnt_q  <= '0;
            dwell_cnt_q <= '0;
            arrived_q   <= 1'b0;
            cmd_drop_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            buzz_cnt_q  <= buzz_cnt_d;
            dwell_cnt_q <= dwell_cnt_d;
            arrived_q   <= arrived_d;
            cmd_drop_q  <= cmd_drop_d;
            timeout_q   <= timeout_d;
        end
    end

    assign arrived  = arrived_q;
    assign cmd_drop = cmd_drop_q;
    assign timeout  = timeout_q;
    assign q_count  = fifo_count;

endmodule
